// File: rtl/player_input_ctrl_pkg.sv
// Shared definitions for the player input conditioning block: attack phase
// encoding and a small sizing helper.
package player_input_ctrl_pkg;

  localparam logic [1:0] PH_IDLE     = 2'd0;
  localparam logic [1:0] PH_STARTUP  = 2'd1;
  localparam logic [1:0] PH_ACTIVE   = 2'd2;
  localparam logic [1:0] PH_RECOVERY = 2'd3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/player_input_ctrl_btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw button, with a
// rising-edge pulse that only fires once the button has been seen released.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [1:0]    warm_q;
  logic          armed_q, armed_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Edges are armed only after a genuine low sample, so a button held
  // through reset never produces a press event.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    armed_d = armed_q | (warm_q[1] & ~sync2_q);
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = level_d & ~level_q & armed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      warm_q  <= 2'b00;
      armed_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      warm_q  <= {warm_q[0], 1'b1};
      armed_q <= armed_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/player_input_ctrl.sv
// Conditions raw buttons into move/jump controls for player_move and runs the
// fixed-timing attack sequence that locks out movement and jumping.
module player_input_ctrl
  import player_input_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STARTUP_CYCLES  = 3,
  parameter int unsigned ACTIVE_CYCLES   = 4,
  parameter int unsigned RECOVERY_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_attack,
  input  logic       jump_active,
  input  logic       stun,
  output logic       move_left,
  output logic       move_right,
  output logic       jump,
  output logic [1:0] attack_phase,
  output logic       attack_hit,
  output logic       busy
);
  localparam int unsigned PW =
    $clog2(max3(STARTUP_CYCLES, ACTIVE_CYCLES, RECOVERY_CYCLES)) + 1;
  localparam logic [PW-1:0] STARTUP_LAST  = PW'(STARTUP_CYCLES - 1);
  localparam logic [PW-1:0] ACTIVE_LAST   = PW'(ACTIVE_CYCLES - 1);
  localparam logic [PW-1:0] RECOVERY_LAST = PW'(RECOVERY_CYCLES - 1);

  logic lvl_left, lvl_right, jump_rise, attack_rise;
  logic unused_rise_left, unused_rise_right, unused_lvl_jump, unused_lvl_attack;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst(rst), .raw(btn_left), .level(lvl_left), .rise(unused_rise_left));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst(rst), .raw(btn_right), .level(lvl_right), .rise(unused_rise_right));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_jump (
    .clk(clk), .rst(rst), .raw(btn_jump), .level(unused_lvl_jump), .rise(jump_rise));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_attack (
    .clk(clk), .rst(rst), .raw(btn_attack), .level(unused_lvl_attack), .rise(attack_rise));

  logic [1:0]    phase_q, phase_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          move_left_q, move_left_d, move_right_q, move_right_d;
  logic          jump_q, jump_d, hit_q, busy_q;
  logic          idle, attack_acc;

  // Attack start has priority over a same-cycle jump; both are dropped under stun.
  always_comb begin
    idle         = (phase_q == PH_IDLE);
    attack_acc   = attack_rise & idle & ~stun;
    jump_d       = jump_rise & ~jump_active & idle & ~stun & ~attack_acc;
    move_left_d  = lvl_left & ~lvl_right & ~busy_q & ~stun;
    move_right_d = lvl_right & ~lvl_left & ~busy_q & ~stun;
    phase_d      = phase_q;
    cnt_d        = cnt_q + PW'(1);
    case (phase_q)
      PH_IDLE: begin
        cnt_d = '0;
        if (attack_acc) phase_d = PH_STARTUP;
      end
      PH_STARTUP: if (cnt_q == STARTUP_LAST) begin
        phase_d = PH_ACTIVE;
        cnt_d   = '0;
      end
      PH_ACTIVE: if (cnt_q == ACTIVE_LAST) begin
        phase_d = PH_RECOVERY;
        cnt_d   = '0;
      end
      PH_RECOVERY: if (cnt_q == RECOVERY_LAST) begin
        phase_d = PH_IDLE;
        cnt_d   = '0;
      end
      default: begin
        phase_d = PH_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (stun) begin
      phase_d = PH_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PH_IDLE;
      cnt_q        <= '0;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      jump_q       <= 1'b0;
      hit_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
      jump_q       <= jump_d;
      hit_q        <= (phase_d == PH_ACTIVE);
      busy_q       <= (phase_d != PH_IDLE);
    end
  end

  assign move_left    = move_left_q;
  assign move_right   = move_right_q;
  assign jump         = jump_q;
  assign attack_phase = phase_q;
  assign attack_hit   = hit_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: directed scenarios with literal expectations plus
// randomized button traffic checked every cycle against a behavioural model.
module tb_player_input_ctrl;
  localparam int D = 4;
  localparam int S = 3;
  localparam int A = 4;
  localparam int R = 6;

  logic clk = 1'b0;
  logic rst, btn_left, btn_right, btn_jump, btn_attack, jump_active, stun;
  logic move_left, move_right, jump, attack_hit, busy;
  logic [1:0] attack_phase;

  int n_tests = 0;
  int n_fail  = 0;

  player_input_ctrl #(
    .DEBOUNCE_CYCLES(D), .STARTUP_CYCLES(S), .ACTIVE_CYCLES(A), .RECOVERY_CYCLES(R)
  ) dut (
    .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right),
    .btn_jump(btn_jump), .btn_attack(btn_attack), .jump_active(jump_active),
    .stun(stun), .move_left(move_left), .move_right(move_right), .jump(jump),
    .attack_phase(attack_phase), .attack_hit(attack_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Attack timeline position -> phase (t < 0 means no attack running).
  function automatic logic [1:0] phase_of(input int t);
    if (t < 0) return 2'd0;
    if (t < S) return 2'd1;
    if (t < S + A) return 2'd2;
    return 2'd3;
  endfunction

  // Behavioural model: button index 0 left, 1 right, 2 jump, 3 attack.
  logic m_d1[4], m_d2[4], m_v1[4], m_v2[4], m_db[4], m_arm[4];
  logic m_win[4][D];
  int   m_nwin[4];
  logic m_ev_j, m_ev_a;
  int   m_t;

  always begin : model
    logic raw[4];
    logic rs, st, ja, busy_old, acc, fire, s, arm_old, differ, ev;
    logic e_ml, e_mr, e_j;
    logic [1:0] e_ph;
    @(posedge clk);
    raw[0] = btn_left; raw[1] = btn_right; raw[2] = btn_jump; raw[3] = btn_attack;
    rs = rst; st = stun; ja = jump_active;
    e_ml = 1'b0; e_mr = 1'b0; e_j = 1'b0;
    if (rs) begin
      for (int b = 0; b < 4; b++) begin
        m_d1[b] = 0; m_d2[b] = 0; m_v1[b] = 0; m_v2[b] = 0;
        m_db[b] = 0; m_arm[b] = 0; m_nwin[b] = 0;
      end
      m_ev_j = 0; m_ev_a = 0; m_t = -1;
    end else begin
      busy_old = (phase_of(m_t) != 2'd0);
      acc  = m_ev_a && !busy_old && !st;
      fire = m_ev_j && !ja && !busy_old && !st && !acc;
      e_ml = m_db[0] && !m_db[1] && !busy_old && !st;
      e_mr = m_db[1] && !m_db[0] && !busy_old && !st;
      e_j  = fire;
      if (st) m_t = -1;
      else if (acc) m_t = 0;
      else if (m_t >= 0) begin
        m_t++;
        if (m_t >= S + A + R) m_t = -1;
      end
      for (int b = 0; b < 4; b++) begin
        s = m_d2[b];
        arm_old = m_arm[b];
        if (m_v2[b] && !s) m_arm[b] = 1;
        for (int i = D - 1; i > 0; i--) m_win[b][i] = m_win[b][i-1];
        m_win[b][0] = s;
        if (m_nwin[b] < D) m_nwin[b]++;
        differ = (m_nwin[b] == D);
        for (int i = 0; i < D; i++) if (m_win[b][i] == m_db[b]) differ = 0;
        ev = 0;
        if (differ) begin
          m_db[b] = !m_db[b];
          ev = m_db[b] && arm_old;
        end
        if (b == 2) m_ev_j = ev;
        if (b == 3) m_ev_a = ev;
        m_d2[b] = m_d1[b]; m_v2[b] = m_v1[b];
        m_d1[b] = raw[b];  m_v1[b] = 1;
      end
    end
    e_ph = phase_of(m_t);
    #1;
    check("cycle_outputs", 32'({move_left, move_right, jump, attack_hit, busy, attack_phase}),
          32'({e_ml, e_mr, e_j, e_ph == 2'd2, e_ph != 2'd0, e_ph}));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int bad, lat, cnt, starts, hits, jumps;
    int pc[4];
    logic [1:0] prev;
    logic found;
    int hold[4];
    logic [3:0] rb;

    rst = 1; btn_left = 1; btn_right = 1; btn_jump = 1; btn_attack = 1;
    jump_active = 0; stun = 0;
    tick(5);
    check("reset_outputs", 32'({move_left, move_right, jump, attack_hit, busy, attack_phase}), 0);
    rst = 0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (jump || busy || move_left || move_right) bad++;
    end
    check("held_after_reset_quiet", 32'(bad), 0);
    btn_left = 0; btn_right = 0; btn_jump = 0; btn_attack = 0;
    tick(12);

    // Movement latency, glitch rejection, left/right arbitration
    btn_left = 1; lat = 0; found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick(1);
      if (move_left) begin lat = i; found = 1; end
    end
    check("move_left_latency", 32'(lat), 7);
    btn_right = 1; tick(3); btn_right = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (move_right || !move_left) bad++;
    end
    check("right_glitch_rejected", 32'(bad), 0);
    btn_right = 1; tick(10);
    check("both_held_no_move", 32'({move_left, move_right}), 0);
    btn_left = 0; btn_right = 0; tick(12);

    // Jump: one pulse per press, none while airborne
    btn_jump = 1; cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(1); cnt += int'(jump); end
    check("jump_single_pulse", 32'(cnt), 1);
    btn_jump = 0; tick(12);
    jump_active = 1; btn_jump = 1; cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(1); cnt += int'(jump); end
    check("jump_blocked_airborne", 32'(cnt), 0);
    btn_jump = 0; tick(12); jump_active = 0;

    // Attack timing with a jump press and a second attack press while busy
    btn_left = 1; tick(10);
    btn_attack = 1;
    pc = '{0, 0, 0, 0}; hits = 0; jumps = 0; starts = 0; prev = 2'd0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) btn_attack = 0;
      if (i == 6) btn_jump = 1;
      if (i == 11) begin btn_jump = 0; btn_attack = 1; end
      if (i == 17) btn_attack = 0;
      tick(1);
      pc[attack_phase]++;
      hits += int'(attack_hit);
      jumps += int'(jump);
      if (attack_phase == 2'd1 && prev == 2'd0) starts++;
      prev = attack_phase;
    end
    check("startup_len", 32'(pc[1]), 3);
    check("active_len", 32'(pc[2]), 4);
    check("recovery_len", 32'(pc[3]), 6);
    check("hit_cycles", 32'(hits), 4);
    check("no_restart", 32'(starts), 1);
    check("no_jump_while_busy", 32'(jumps), 0);
    btn_left = 0; tick(15);

    // Simultaneous jump and attack: attack wins
    starts = 0; jumps = 0; prev = attack_phase;
    btn_jump = 1; btn_attack = 1;
    for (int i = 0; i < 30; i++) begin
      if (i == 6) begin btn_jump = 0; btn_attack = 0; end
      tick(1);
      jumps += int'(jump);
      if (attack_phase == 2'd1 && prev == 2'd0) starts++;
      prev = attack_phase;
    end
    check("simul_attack_started", 32'(starts), 1);
    check("simul_jump_dropped", 32'(jumps), 0);
    tick(10);

    // Stun cancels ACTIVE; a fresh press afterwards is accepted
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      btn_attack = (i < 6);
      tick(1);
      if (attack_phase == 2'd2) found = 1;
    end
    check("reach_active", 32'(found), 1);
    btn_attack = 0;
    stun = 1; tick(1); stun = 0;
    check("stun_cancel", 32'({attack_phase, attack_hit, busy}), 0);
    tick(12);
    found = 0;
    for (int i = 0; i < 25 && !found; i++) begin
      btn_attack = (i < 6);
      tick(1);
      if (attack_phase == 2'd1) found = 1;
    end
    check("attack_after_stun", 32'(found), 1);
    btn_attack = 0; tick(25);

    // Randomized traffic against the model
    rb = 4'b0000;
    for (int b = 0; b < 4; b++) hold[b] = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        hold[b]--;
        if (hold[b] == 0) begin
          rb[b] = ~rb[b];
          hold[b] = int'($urandom_range(1, 12));
        end
      end
      btn_left = rb[0]; btn_right = rb[1]; btn_jump = rb[2]; btn_attack = rb[3];
      if ($urandom_range(0, 15) == 0) jump_active = ~jump_active;
      stun = ($urandom_range(0, 39) == 0);
      rst = (c == 1500 || c == 1501);
      tick(1);
    end
    rst = 0; stun = 0; btn_left = 0; btn_right = 0; btn_jump = 0; btn_attack = 0;
    tick(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
